// File: rtl/systolic_pe_v2_pkg.sv
// Shared types, default widths and the saturating-add helper for the systolic PE.
package systolic_pkg;

   typedef enum logic {WAIT = 1'b0, HELD = 1'b1} pe_state_e;

   localparam int BW_ACT_DEF  = 8;
   localparam int BW_WET_DEF  = 8;
   localparam int BW_ACCU_DEF = 32;

   typedef struct packed {
      logic signed [63:0] val;
      logic               ovf;
   } sat_res_t;

   // sum is the sign-extended BW_ACCU+1 bit sum; bw must be at most 63.
   function automatic sat_res_t sat_add(input logic signed [63:0] sum, input int bw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      sat_res_t           r;
      hi    = (64'sd1 <<< (bw - 1)) - 64'sd1;
      lo    = -(64'sd1 <<< (bw - 1));
      r.val = sum;
      r.ovf = 1'b0;
      if (sum > hi) begin
         r.val = hi;
         r.ovf = 1'b1;
      end else if (sum < lo) begin
         r.val = lo;
         r.ovf = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/systolic_pe_v2_if.sv
// Per-PE signal bundle: weight, activation and partial-sum flow plus swap status.
interface systolic_pe_v2_if
   import systolic_pkg::*;
#(
   parameter int BW_ACT  = BW_ACT_DEF,
   parameter int BW_WET  = BW_WET_DEF,
   parameter int BW_ACCU = BW_ACCU_DEF
);
   logic                      clear_weight;
   logic                      wet_in_valid;
   logic signed [BW_WET-1:0]  wet_in;
   logic                      wet_out_valid;
   logic signed [BW_WET-1:0]  wet_out;
   logic                      wet_swap;
   logic                      act_in_valid;
   logic signed [BW_ACT-1:0]  act_in;
   logic                      act_out_valid;
   logic signed [BW_ACT-1:0]  act_out;
   logic                      psum_in_valid;
   logic signed [BW_ACCU-1:0] psum_in;
   logic                      psum_out_valid;
   logic signed [BW_ACCU-1:0] psum_out;
   logic                      psum_ovf;
   logic                      wet_ready;
   logic                      swap_err;

   modport slave (
      input  clear_weight, wet_in_valid, wet_in, wet_swap,
             act_in_valid, act_in, psum_in_valid, psum_in,
      output wet_out_valid, wet_out, act_out_valid, act_out,
             psum_out_valid, psum_out, psum_ovf, wet_ready, swap_err
   );

   modport master (
      output clear_weight, wet_in_valid, wet_in, wet_swap,
             act_in_valid, act_in, psum_in_valid, psum_in,
      input  wet_out_valid, wet_out, act_out_valid, act_out,
             psum_out_valid, psum_out, psum_ovf, wet_ready, swap_err
   );

endinterface

// File: rtl/systolic_pe_v2_mac.sv
// Two-stage MAC: registered product, then widened add with optional clamp.
module pe_mac_pipe
   import systolic_pkg::*;
#(
   parameter int BW_ACT   = BW_ACT_DEF,
   parameter int BW_WET   = BW_WET_DEF,
   parameter int BW_ACCU  = BW_ACCU_DEF,
   parameter int SATURATE = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      act_valid,
   input  logic signed [BW_ACT-1:0]  act,
   input  logic signed [BW_WET-1:0]  wet,
   input  logic                      psum_valid,
   input  logic signed [BW_ACCU-1:0] psum,
   output logic                      out_valid,
   output logic signed [BW_ACCU-1:0] out_psum,
   output logic                      out_ovf
);
   localparam int PW = BW_ACT + BW_WET;

   logic                      vld_p1;
   logic signed [PW-1:0]      prod_p1;
   logic signed [BW_ACCU-1:0] psum_p1;
   logic signed [BW_ACCU:0]   sum_p1;
   logic signed [BW_ACCU-1:0] res_p1;
   sat_res_t                  sat_p1;
   logic                      unused_sat_hi;

   logic                      vld_p2;
   logic signed [BW_ACCU-1:0] psum_p2;
   logic                      ovf_p2;

   // Stage 1: multiply; a missing upstream partial sum contributes zero.
   always_ff @(posedge clk) begin
      if (reset) vld_p1 <= 1'b0;
      else       vld_p1 <= act_valid;
   end

   always_ff @(posedge clk) begin
      if (act_valid) begin
         prod_p1 <= PW'(act) * PW'(wet);
         psum_p1 <= psum_valid ? psum : '0;
      end
   end

   // Stage 2: add at BW_ACCU+1 bits so the overflow is visible, then clamp or wrap.
   assign sum_p1        = (BW_ACCU + 1)'(prod_p1) + (BW_ACCU + 1)'(psum_p1);
   assign sat_p1        = sat_add(64'(sum_p1), BW_ACCU);
   assign res_p1        = (SATURATE != 0) ? sat_p1.val[BW_ACCU-1:0] : sum_p1[BW_ACCU-1:0];
   assign unused_sat_hi = ^sat_p1.val[63:BW_ACCU];

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p2  <= 1'b0;
         psum_p2 <= '0;
         ovf_p2  <= 1'b0;
      end else begin
         vld_p2 <= vld_p1;
         ovf_p2 <= vld_p1 & sat_p1.ovf;
         if (vld_p1) psum_p2 <= res_p1;
      end
   end

   assign out_valid = vld_p2;
   assign out_psum  = psum_p2;
   assign out_ovf   = ovf_p2;

endmodule

// File: rtl/systolic_pe_v2.sv
// Weight-stationary PE: row-indexed shadow capture, shadow/active swap, forwarding and MAC.
module systolic_pe_v2
   import systolic_pkg::*;
#(
   parameter int BW_ACT   = BW_ACT_DEF,
   parameter int BW_WET   = BW_WET_DEF,
   parameter int BW_ACCU  = BW_ACCU_DEF,
   parameter int ROW_IDX  = 0,
   parameter int SATURATE = 1
) (
   input logic             clk,
   input logic             reset,
   systolic_pe_v2_if.slave pe
);
   localparam int             CW      = (ROW_IDX < 1) ? 1 : $clog2(ROW_IDX + 1);
   localparam logic [CW-1:0]  ROW_CNT = CW'(ROW_IDX);

   pe_state_e                state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic signed [BW_WET-1:0] shadow_q, shadow_d;
   logic signed [BW_WET-1:0] active_q, active_d;
   logic                     swap_err_q, swap_err_d;

   logic                     swap_ok;
   logic                     beat_wait;
   logic [CW-1:0]            beat_cnt;

   // An accepted swap restarts the load, so a coincident beat is beat 0.
   assign swap_ok   = pe.wet_swap && (state_q == HELD);
   assign beat_wait = swap_ok || (state_q == WAIT);
   assign beat_cnt  = swap_ok ? '0 : cnt_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      active_d   = active_q;
      swap_err_d = swap_err_q;
      if (pe.clear_weight) begin
         state_d    = WAIT;
         cnt_d      = '0;
         shadow_d   = '0;
         active_d   = '0;
         swap_err_d = 1'b0;
      end else begin
         if (swap_ok) begin
            active_d = shadow_q;
            cnt_d    = '0;
            state_d  = WAIT;
         end else if (pe.wet_swap) begin
            swap_err_d = 1'b1;
         end
         if (pe.wet_in_valid && beat_wait) begin
            if (beat_cnt == ROW_CNT) begin
               shadow_d = pe.wet_in;
               state_d  = HELD;
            end else begin
               cnt_d = beat_cnt + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WAIT;
         cnt_q      <= '0;
         shadow_q   <= '0;
         active_q   <= '0;
         swap_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         swap_err_q <= swap_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pe.act_out_valid <= 1'b0;
         pe.act_out       <= '0;
         pe.wet_out_valid <= 1'b0;
         pe.wet_out       <= '0;
      end else begin
         pe.act_out_valid <= pe.act_in_valid;
         pe.act_out       <= pe.act_in;
         pe.wet_out_valid <= pe.wet_in_valid;
         pe.wet_out       <= pe.wet_in;
      end
   end

   assign pe.wet_ready = (state_q == HELD);
   assign pe.swap_err  = swap_err_q;

   pe_mac_pipe #(
      .BW_ACT   (BW_ACT),
      .BW_WET   (BW_WET),
      .BW_ACCU  (BW_ACCU),
      .SATURATE (SATURATE)
   ) u_mac (
      .clk        (clk),
      .reset      (reset),
      .act_valid  (pe.act_in_valid),
      .act        (pe.act_in),
      .wet        (active_q),
      .psum_valid (pe.psum_in_valid),
      .psum       (pe.psum_in),
      .out_valid  (pe.psum_out_valid),
      .out_psum   (pe.psum_out),
      .out_ovf    (pe.psum_ovf)
   );

endmodule

// File: tb/tb_systolic_pe_v2.sv
// Directed bench: weight capture/forward, swap rules, MAC latency, saturate vs wrap, reset flush.
module tb_systolic_pe_v2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   systolic_pe_v2_if #(.BW_ACT(8), .BW_WET(8), .BW_ACCU(32)) m_if ();
   systolic_pe_v2_if #(.BW_ACT(8), .BW_WET(8), .BW_ACCU(16)) s_if ();
   systolic_pe_v2_if #(.BW_ACT(8), .BW_WET(8), .BW_ACCU(16)) w_if ();

   systolic_pe_v2 #(.BW_ACT(8), .BW_WET(8), .BW_ACCU(32), .ROW_IDX(2), .SATURATE(1))
      u_main (.clk(clk), .reset(reset), .pe(m_if));
   systolic_pe_v2 #(.BW_ACT(8), .BW_WET(8), .BW_ACCU(16), .ROW_IDX(0), .SATURATE(1))
      u_sat (.clk(clk), .reset(reset), .pe(s_if));
   systolic_pe_v2 #(.BW_ACT(8), .BW_WET(8), .BW_ACCU(16), .ROW_IDX(0), .SATURATE(0))
      u_wrap (.clk(clk), .reset(reset), .pe(w_if));

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic m_act(input logic v, input logic signed [7:0] a,
                        input logic pv, input logic signed [31:0] p);
      m_if.act_in_valid  = v;
      m_if.act_in        = a;
      m_if.psum_in_valid = pv;
      m_if.psum_in       = p;
   endtask

   task automatic m_beat(input logic v, input logic signed [7:0] w);
      m_if.wet_in_valid = v;
      m_if.wet_in       = w;
   endtask

   task automatic sw_drive(input logic wv, input logic signed [7:0] w, input logic swp,
                           input logic av, input logic signed [7:0] a, input logic signed [15:0] p);
      s_if.wet_in_valid = wv;  w_if.wet_in_valid = wv;
      s_if.wet_in = w;         w_if.wet_in = w;
      s_if.wet_swap = swp;     w_if.wet_swap = swp;
      s_if.act_in_valid = av;  w_if.act_in_valid = av;
      s_if.act_in = a;         w_if.act_in = a;
      s_if.psum_in_valid = av; w_if.psum_in_valid = av;
      s_if.psum_in = p;        w_if.psum_in = p;
   endtask

   initial begin
      logic signed [7:0] beats [4];
      logic              rdy   [4];
      beats = '{8'sd5, 8'sd6, 8'sd7, 8'sd8};
      rdy   = '{1'b0, 1'b0, 1'b1, 1'b1};

      m_if.clear_weight = 1'b0;
      m_if.wet_swap     = 1'b0;
      m_beat(1'b0, 8'sd0);
      m_act(1'b0, 8'sd0, 1'b0, 32'sd0);
      s_if.clear_weight = 1'b0;
      w_if.clear_weight = 1'b0;
      sw_drive(1'b0, 8'sd0, 1'b0, 1'b0, 8'sd0, 16'sd0);

      tick();
      tick();
      chk("rst_psum_vld", m_if.psum_out_valid, 0);
      chk("rst_psum", m_if.psum_out, 0);
      chk("rst_ready", m_if.wet_ready, 0);
      chk("rst_swap_err", m_if.swap_err, 0);
      chk("rst_act_vld", m_if.act_out_valid, 0);
      chk("rst_wet_vld", m_if.wet_out_valid, 0);
      chk("rst_ovf", s_if.psum_ovf, 0);
      reset = 1'b0;

      // ROW_IDX=2 captures the third beat; all beats are forwarded a cycle later.
      for (int i = 0; i < 4; i++) begin
         m_beat(1'b1, beats[i]);
         tick();
         chk("wet_out", m_if.wet_out, beats[i]);
         chk("wet_out_vld", m_if.wet_out_valid, 1);
         chk("wet_ready", m_if.wet_ready, rdy[i]);
      end
      m_beat(1'b0, 8'sd0);
      tick();
      chk("wet_out_vld_lo", m_if.wet_out_valid, 0);
      chk("ready_held", m_if.wet_ready, 1);

      m_if.wet_swap = 1'b1;
      tick();
      m_if.wet_swap = 1'b0;
      chk("ready_after_swap", m_if.wet_ready, 0);
      chk("no_swap_err", m_if.swap_err, 0);

      // Back-to-back stream with active weight 7.
      m_act(1'b1, 8'sd3, 1'b1, 32'sd10);
      tick();
      chk("act_out", m_if.act_out, 3);
      chk("act_out_vld", m_if.act_out_valid, 1);
      chk("lat1_no_psum", m_if.psum_out_valid, 0);
      m_act(1'b1, 8'sd4, 1'b1, 32'sd1);
      tick();
      chk("mac0_vld", m_if.psum_out_valid, 1);
      chk("mac0", m_if.psum_out, 31);
      chk("mac0_ovf", m_if.psum_ovf, 0);
      m_act(1'b1, -8'sd2, 1'b0, 32'sd99);
      tick();
      chk("mac1", m_if.psum_out, 29);
      m_act(1'b0, 8'sd0, 1'b0, 32'sd0);
      tick();
      chk("mac2_nopsum", m_if.psum_out, -14);
      chk("mac2_vld", m_if.psum_out_valid, 1);
      tick();
      chk("idle_vld", m_if.psum_out_valid, 0);
      chk("idle_hold", m_if.psum_out, -14);

      // Swap while waiting: flagged, active weight kept.
      m_if.wet_swap = 1'b1;
      tick();
      m_if.wet_swap = 1'b0;
      chk("swap_err_set", m_if.swap_err, 1);
      m_act(1'b1, 8'sd1, 1'b1, 32'sd0);
      tick();
      m_act(1'b0, 8'sd0, 1'b0, 32'sd0);
      tick();
      chk("active_kept", m_if.psum_out, 7);
      chk("swap_err_sticky", m_if.swap_err, 1);
      m_if.clear_weight = 1'b1;
      tick();
      m_if.clear_weight = 1'b0;
      chk("swap_err_clr", m_if.swap_err, 0);
      m_act(1'b1, 8'sd5, 1'b1, 32'sd0);
      tick();
      m_act(1'b0, 8'sd0, 1'b0, 32'sd0);
      tick();
      chk("cleared_weight", m_if.psum_out, 0);

      // Load 2, then a swap with a coincident beat 0, then load 4.
      m_beat(1'b1, 8'sd1); tick();
      m_beat(1'b1, 8'sd1); tick();
      m_beat(1'b1, 8'sd2); tick();
      m_if.wet_swap = 1'b1;
      m_beat(1'b1, 8'sd9); tick();
      m_if.wet_swap = 1'b0;
      chk("ready_swap_beat", m_if.wet_ready, 0);
      m_beat(1'b1, 8'sd9); tick();
      m_beat(1'b1, 8'sd4); tick();
      m_beat(1'b0, 8'sd0);
      chk("ready_reload", m_if.wet_ready, 1);

      // Swap coincident with an activation uses the old weight.
      m_if.wet_swap = 1'b1;
      m_act(1'b1, 8'sd5, 1'b1, 32'sd0);
      tick();
      m_if.wet_swap = 1'b0;
      m_act(1'b1, 8'sd5, 1'b0, 32'sd0);
      tick();
      chk("swap_same_old", m_if.psum_out, 10);
      m_act(1'b0, 8'sd0, 1'b0, 32'sd0);
      tick();
      chk("swap_same_new", m_if.psum_out, 20);

      // Reset one cycle after an activation flushes the pipeline.
      m_act(1'b1, 8'sd5, 1'b1, 32'sd3);
      tick();
      m_act(1'b0, 8'sd5, 1'b0, 32'sd0);
      reset = 1'b1;
      tick();
      chk("flush_vld", m_if.psum_out_valid, 0);
      chk("flush_psum", m_if.psum_out, 0);
      chk("flush_act_vld", m_if.act_out_valid, 0);
      chk("flush_act", m_if.act_out, 0);
      reset = 1'b0;
      tick();
      chk("flush_no_beat", m_if.psum_out_valid, 0);

      // 16-bit accumulator: 127*127+32767 and -128*127-32768 overflow both ways.
      sw_drive(1'b1, 8'sd127, 1'b0, 1'b0, 8'sd0, 16'sd0);
      tick();
      sw_drive(1'b0, 8'sd0, 1'b1, 1'b0, 8'sd0, 16'sd0);
      chk("sat_ready", s_if.wet_ready, 1);
      tick();
      sw_drive(1'b0, 8'sd0, 1'b0, 1'b1, 8'sd127, 16'sd32767);
      tick();
      sw_drive(1'b0, 8'sd0, 1'b0, 1'b1, 8'sh80, 16'sh8000);
      tick();
      chk("sat_pos", s_if.psum_out, 32767);
      chk("sat_pos_ovf", s_if.psum_ovf, 1);
      chk("wrap_pos", w_if.psum_out, -16640);
      chk("wrap_pos_ovf", w_if.psum_ovf, 1);
      sw_drive(1'b0, 8'sd0, 1'b0, 1'b0, 8'sd0, 16'sd0);
      tick();
      chk("sat_neg", s_if.psum_out, -32768);
      chk("sat_neg_ovf", s_if.psum_ovf, 1);
      chk("wrap_neg", w_if.psum_out, 16512);
      chk("wrap_neg_ovf", w_if.psum_ovf, 1);
      tick();
      chk("sat_ovf_idle", s_if.psum_ovf, 0);
      chk("wrap_ovf_idle", w_if.psum_ovf, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
